// File: rtl/lerp_pkg.sv
// Shared types, default widths and width helpers for the pipelined interpolator.
package lerp_pkg;

  typedef enum logic {
    ROUND_TRUNC   = 1'b0,
    ROUND_HALF_UP = 1'b1
  } round_mode_e;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_DECIMALS = 16;
  localparam int unsigned DEF_CHANNELS = 4;

  localparam int unsigned DIFF_W = DEF_WIDTH + 1;
  localparam int unsigned PROD_W = DEF_WIDTH + DEF_DECIMALS + 2;

  function automatic int unsigned ch_width(input int unsigned channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  function automatic int unsigned diff_width(input int unsigned width);
    return width + 1;
  endfunction

  function automatic int unsigned prod_width(input int unsigned width, input int unsigned decimals);
    return width + decimals + 2;
  endfunction

endpackage

// File: rtl/lerp_mul_stage.sv
// Registered exact signed multiply of the sample difference by the unsigned fraction.
module lerp_mul_stage
  import lerp_pkg::*;
#(
  parameter int unsigned DIFF_BITS = DIFF_W,
  parameter int unsigned FRAC_BITS = DEF_DECIMALS,
  parameter int unsigned PROD_BITS = PROD_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic signed [DIFF_BITS-1:0] diff,
  input  logic        [FRAC_BITS-1:0] frac,
  output logic signed [PROD_BITS-1:0] prod
);

  logic signed [PROD_BITS-1:0] prod_c;

  // Fraction is zero-extended so it multiplies as a non-negative signed value.
  assign prod_c = PROD_BITS'(diff) * PROD_BITS'($signed({1'b0, frac}));

  always_ff @(posedge clk) begin
    if (reset) begin
      prod <= '0;
    end else if (en) begin
      prod <= prod_c;
    end
  end

endmodule

// File: rtl/lerp_pipe.sv
// Three-stage multi-channel linear interpolator with valid/ready on both sides.
module lerp_pipe
  import lerp_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DECIMALS = DEF_DECIMALS,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned ROUND    = 0,
  localparam int unsigned CH_W    = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_first,
  input  logic [WIDTH-1:0]    in_second,
  input  logic [DECIMALS-1:0] in_frac,
  input  logic [CH_W-1:0]     in_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [CH_W-1:0]     out_ch
);

  localparam int unsigned DIFF_BITS = diff_width(WIDTH);
  localparam int unsigned PROD_BITS = prod_width(WIDTH, DECIMALS);
  localparam round_mode_e RMODE     = (ROUND != 0) ? ROUND_HALF_UP : ROUND_TRUNC;
  localparam logic signed [PROD_BITS-1:0] RND =
    (RMODE == ROUND_HALF_UP) ? (PROD_BITS'(1) << (DECIMALS - 1)) : '0;

  logic advance;

  logic                        s1_valid;
  logic signed [WIDTH-1:0]     s1_first;
  logic signed [DIFF_BITS-1:0] s1_diff;
  logic [DECIMALS-1:0]         s1_frac;
  logic [CH_W-1:0]             s1_ch;

  logic                        s2_valid;
  logic signed [WIDTH-1:0]     s2_first;
  logic signed [PROD_BITS-1:0] s2_prod;
  logic [CH_W-1:0]             s2_ch;

  logic signed [DIFF_BITS-1:0] diff_c;
  logic signed [PROD_BITS-1:0] q_c;

  // All stages move in lockstep; only a held output blocks the pipe.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign diff_c = DIFF_BITS'($signed(in_second)) - DIFF_BITS'($signed(in_first));
  assign q_c    = (s2_prod + RND) >>> DECIMALS;

  // S1: capture operands and form the exact difference.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= '0;
      s1_diff  <= '0;
      s1_frac  <= '0;
      s1_ch    <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_first <= $signed(in_first);
        s1_diff  <= diff_c;
        s1_frac  <= in_frac;
        s1_ch    <= in_ch;
      end
    end
  end

  lerp_mul_stage #(
    .DIFF_BITS (DIFF_BITS),
    .FRAC_BITS (DECIMALS),
    .PROD_BITS (PROD_BITS)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .en    (advance && s1_valid),
    .diff  (s1_diff),
    .frac  (s1_frac),
    .prod  (s2_prod)
  );

  // S2: side-band that travels alongside the multiplier register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_first <= '0;
      s2_ch    <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first <= s1_first;
        s2_ch    <= s1_ch;
      end
    end
  end

  // S3: scale, add back the start sample; result is bounded by the endpoints.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= s2_first + WIDTH'(q_c);
        out_ch   <= s2_ch;
      end
    end
  end

endmodule

// File: tb/tb_lerp_pipe.sv
// Directed and randomised checks of lerp_pipe in truncate and round-half-up modes.
module tb_lerp_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_first;
  logic [31:0] in_second;
  logic [15:0] in_frac;
  logic [1:0]  in_ch;

  logic        in_ready,  in_ready_r;
  logic        out_valid, out_valid_r;
  logic [31:0] out_data,  out_data_r;
  logic [1:0]  out_ch,    out_ch_r;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  ch;
  } exp_t;

  always #5 clk = ~clk;

  lerp_pipe #(.WIDTH(32), .DECIMALS(16), .CHANNELS(4), .ROUND(0)) dut (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_first (in_first), .in_second (in_second), .in_frac (in_frac), .in_ch (in_ch),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_ch (out_ch)
  );

  lerp_pipe #(.WIDTH(32), .DECIMALS(16), .CHANNELS(4), .ROUND(1)) dut_r (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_ready (in_ready_r),
    .in_first (in_first), .in_second (in_second), .in_frac (in_frac), .in_ch (in_ch),
    .out_valid (out_valid_r), .out_ready (out_ready), .out_data (out_data_r), .out_ch (out_ch_r)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: first + floor((diff*frac + rnd) / 2^16) in 64-bit signed arithmetic.
  function automatic logic [31:0] model(input logic [31:0] f, input logic [31:0] s,
                                        input logic [15:0] fr, input bit rnd);
    longint d;
    longint p;
    d = longint'($signed(s)) - longint'($signed(f));
    p = d * longint'({48'd0, fr}) + (rnd ? 64'sd32768 : 64'sd0);
    return 32'(longint'($signed(f)) + (p >>> 16));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [31:0] f, input logic [31:0] s,
                          input logic [15:0] fr, input logic [1:0] c,
                          input logic [31:0] exp0, input logic [31:0] exp1);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_first  = f;
    in_second = s;
    in_frac   = fr;
    in_ch     = c;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_data"}, 64'(out_data), 64'(exp0));
    check({tag, "_data_rnd"}, 64'(out_data_r), 64'(exp1));
    check({tag, "_ch"}, 64'(out_ch), 64'(c));
    tick();
  endtask

  task automatic run_stream(input string tag, input int n, input bit rnd_mode);
    exp_t        sb[$];
    exp_t        e;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    bit          have = 1'b0;
    bit          held = 1'b0;
    logic [31:0] held_d;
    logic [1:0]  held_c;
    logic [31:0] f, s;
    logic [15:0] fr;
    logic [1:0]  c;
    while ((sent < n || sb.size() != 0) && cyc < 60000) begin
      if (!have && sent < n) begin
        if (rnd_mode) begin
          f  = $urandom();
          s  = $urandom();
          fr = 16'($urandom());
          c  = 2'($urandom());
        end else begin
          f  = 32'(sent * 10);
          s  = 32'(sent * 10 + 100);
          fr = 16'h8000;
          c  = 2'(sent % 4);
        end
        have = 1'b1;
      end
      in_valid  = have && (rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1);
      in_first  = f;
      in_second = s;
      in_frac   = fr;
      in_ch     = c;
      out_ready = rnd_mode ? ($urandom_range(0, 9) < 7) : !(cyc >= 5 && cyc < 10);
      #1;
      if (held) begin
        check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hold_data"}, 64'(out_data), 64'(held_d));
        check({tag, "_hold_ch"}, 64'(out_ch), 64'(held_c));
      end
      if (out_valid && !out_ready)
        check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
      if (in_valid && in_ready) begin
        e.e0 = model(f, s, fr, 1'b0);
        e.e1 = model(f, s, fr, 1'b1);
        e.ch = c;
        sb.push_back(e);
        sent++;
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check({tag, "_unexpected_out"}, 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({tag, "_data"}, 64'(out_data), 64'(e.e0));
          check({tag, "_data_rnd"}, 64'(out_data_r), 64'(e.e1));
          check({tag, "_ch"}, 64'(out_ch), 64'(e.ch));
          got++;
        end
      end
      held   = out_valid && !out_ready;
      held_d = out_data;
      held_c = out_ch;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, 64'(got), 64'(n));
    check({tag, "_leftover"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    bit stale;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_first  = '0;
    in_second = '0;
    in_frac   = '0;
    in_ch     = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    send_one("mid",     32'd100, 32'd200, 16'h8000, 2'd2, 32'd150, 32'd150);
    send_one("desc",    32'd200, 32'd100, 16'h4000, 2'd1, 32'd175, 32'd175);
    send_one("neg_rnd", 32'd0, 32'hFFFF_FFFD, 16'h8000, 2'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    send_one("full",    32'h8000_0000, 32'h7FFF_FFFF, 16'hFFFF, 2'd0, 32'h7FFE_FFFF, 32'h7FFE_FFFF);
    send_one("frac0",   32'h8000_0000, 32'h7FFF_FFFF, 16'h0000, 2'd1, 32'h8000_0000, 32'h8000_0000);
    send_one("equal",   32'd1234, 32'd1234, 16'hABCD, 2'd2, 32'd1234, 32'd1234);

    run_stream("stream", 8, 1'b0);

    // Reset with samples in flight must flush everything.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_first  = 32'(i * 1000);
      in_second = 32'(i * 1000 + 500);
      in_frac   = 16'h1234;
      in_ch     = 2'(i);
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_data", 64'(out_data), 64'd0);
    check("flush_out_valid_rnd", 64'(out_valid_r), 64'd0);
    reset = 1'b0;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    stale = 1'b0;
    repeat (8) begin
      tick();
      if (out_valid || out_valid_r) stale = 1'b1;
    end
    check("flush_no_stale", 64'(stale), 64'd0);

    run_stream("random", 10000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
